sseg_frame_arbiter: RTL and testbench

//  Shares the 8-digit seven-segment driver between three display clients:

---
 rtl/sseg_frame_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_sseg_frame_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_frame_arbiter
//  Description : Round-robin arbiter that shares one 8-digit seven-segment
//                driver between three display clients. The arbiter enforces a
//                minimum hold time before another client can take over. It
//                registers the owner's frame onto the digit inputs, applies
//                optional blinking, and blanks the display when idle.
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_frame_arbiter #(
    parameter int HOLD_TICKS  = 100_000_000,
    parameter int BLINK_TICKS = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  blink,
    input  logic [47:0] frame0,
    input  logic [47:0] frame1,
    input  logic [47:0] frame2,
    output logic [2:0]  gnt,
    output logic        busy,
    output logic [5:0]  I0,
    output logic [5:0]  I1,
    output logic [5:0]  I2,
    output logic [5:0]  I3,
    output logic [5:0]  I4,
    output logic [5:0]  I5,
    output logic [5:0]  I6,
    output logic [5:0]  I7
);

    localparam int                 c_MAX_TICKS  = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
    localparam int                 c_CNT_W      = $clog2(c_MAX_TICKS + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(HOLD_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_BLINK_LAST = c_CNT_W'(BLINK_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_OWN  = 1'b1;

    // Index of a one-hot grant vector (0 when the vector is empty).
    function automatic logic [1:0] f_onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    // First requester after position p, searching p+1, p+2, p (mod 3).
    function automatic logic [2:0] f_rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] pick;
        a    = (p == 2'd2) ? 2'd0 : p + 2'd1;
        b    = (a == 2'd2) ? 2'd0 : a + 2'd1;
        pick = 3'b000;
        if (r[a])      pick[a] = 1'b1;
        else if (r[b]) pick[b] = 1'b1;
        else if (r[p]) pick[p] = 1'b1;
        return pick;
    endfunction

    logic [0:0]         r_state;
    logic [2:0]         r_gnt;
    logic [1:0]         r_ptr;
    logic [c_CNT_W-1:0] r_hold;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic [7:0][5:0]    r_digits;

    logic [0:0]         w_state_nxt;
    logic [2:0]         w_gnt_nxt;
    logic [1:0]         w_ptr_nxt;
    logic [c_CNT_W-1:0] w_hold_nxt;

    logic [1:0]         w_owner;
    logic [2:0]         w_others;
    logic [2:0]         w_rotate;
    logic               w_owner_req;
    logic               w_owner_blink;
    logic               w_blank;
    logic [47:0]        w_frame;
    logic [7:0][5:0]    w_digits;

    assign w_owner       = f_onehot_idx(r_gnt);
    assign w_others      = req & ~r_gnt;
    assign w_rotate      = f_rr_pick(w_others, w_owner);
    assign w_owner_req   = |(req & r_gnt);
    assign w_owner_blink = |(blink & r_gnt);
    assign w_blank       = w_owner_blink & ~r_blink_on;

    // Arbitration: pick the next owner, hold time and last-owner pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            c_S_IDLE: begin
                if (req != 3'b000) begin
                    w_gnt_nxt   = f_rr_pick(req, r_ptr);
                    w_hold_nxt  = c_HOLD_LOAD;
                    w_state_nxt = c_S_OWN;
                end
            end
            c_S_OWN: begin
                if (!w_owner_req) begin
                    // Release: hand straight over to a waiting client if any.
                    w_ptr_nxt = w_owner;
                    w_gnt_nxt = w_rotate;
                    if (w_others != 3'b000) begin
                        w_hold_nxt  = c_HOLD_LOAD;
                        w_state_nxt = c_S_OWN;
                    end else begin
                        w_hold_nxt  = '0;
                        w_state_nxt = c_S_IDLE;
                    end
                end else if (r_hold == '0) begin
                    // Hold expired: rotate only if someone else is waiting.
                    if (w_others != 3'b000) begin
                        w_ptr_nxt  = w_owner;
                        w_gnt_nxt  = w_rotate;
                        w_hold_nxt = c_HOLD_LOAD;
                    end
                end else begin
                    w_hold_nxt = r_hold - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_gnt_nxt   = 3'b000;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_gnt   <= 3'b000;
            r_ptr   <= 2'd2;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Blink timer: restarts in the on phase on ownership change or blink off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if ((w_gnt_nxt != r_gnt) || !w_owner_blink) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_CNT_ONE;
        end
    end

    // Frame of the current owner; all zero when nobody is granted.
    always_comb begin
        w_frame = 48'd0;
        case (r_gnt)
            3'b001:  w_frame = frame0;
            3'b010:  w_frame = frame1;
            3'b100:  w_frame = frame2;
            default: w_frame = 48'd0;
        endcase
    end

    // Off phase of blink clears each digit's enable; hex and dp pass through.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign w_digits[gi] = {w_frame[6*gi+5] & ~w_blank, w_frame[6*gi +: 5]};
        end
    endgenerate

    // Digit output registers, refreshed every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= '0;
        end else begin
            r_digits <= w_digits;
        end
    end

    assign gnt  = r_gnt;
    assign busy = |r_gnt;
    assign I0   = r_digits[0];
    assign I1   = r_digits[1];
    assign I2   = r_digits[2];
    assign I3   = r_digits[3];
    assign I4   = r_digits[4];
    assign I5   = r_digits[5];
    assign I6   = r_digits[6];
    assign I7   = r_digits[7];

    // The grant is never multi-hot.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(r_gnt));

endmodule
`default_nettype wire

// File: tb/tb_sseg_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_frame_arbiter
//  Description : Self-checking bench for sseg_frame_arbiter. Uses a vector
//                table, a few hand sequences and a random run that is checked
//                against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sseg_frame_arbiter;

    localparam int HOLD  = 4;
    localparam int BT    = 2;
    localparam int NVEC  = 35;
    localparam int NRAND = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  blink = 3'b000;
    logic [47:0] frame0 = 48'd0;
    logic [47:0] frame1 = 48'd0;
    logic [47:0] frame2 = 48'd0;
    logic [2:0]  gnt;
    logic        busy;
    logic [5:0]  I0, I1, I2, I3, I4, I5, I6, I7;
    logic [47:0] all_i;

    assign all_i = {I7, I6, I5, I4, I3, I2, I1, I0};

    sseg_frame_arbiter #(
        .HOLD_TICKS  (HOLD),
        .BLINK_TICKS (BT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .blink  (blink),
        .frame0 (frame0),
        .frame1 (frame1),
        .frame2 (frame2),
        .gnt    (gnt),
        .busy   (busy),
        .I0     (I0),
        .I1     (I1),
        .I2     (I2),
        .I3     (I3),
        .I4     (I4),
        .I5     (I5),
        .I6     (I6),
        .I7     (I7)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // owner is an index (-1 = nobody), age counts cycles since the grant,
    // run counts consecutive owned cycles with the owner's blink high.
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_ptr   = 2;
    int          m_run   = 0;
    logic [2:0]  m_gnt   = 3'b000;
    logic [47:0] m_i     = 48'd0;

    function automatic int next_after(input logic [2:0] r, input int p);
        for (int k = 1; k <= 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [47:0] fr [3];
        logic [2:0]  others;
        logic [5:0]  dig;
        int          nxt;
        fr[0] = frame0;
        fr[1] = frame1;
        fr[2] = frame2;
        if (reset) begin
            m_owner = -1;
            m_age   = 0;
            m_ptr   = 2;
            m_run   = 0;
            m_i     = 48'd0;
        end else begin
            if (m_owner < 0) begin
                m_i = 48'd0;
            end else begin
                for (int d = 0; d < 8; d++) begin
                    dig = fr[m_owner][6*d +: 6];
                    if (blink[m_owner] && ((m_run / BT) % 2 == 1)) dig[5] = 1'b0;
                    m_i[6*d +: 6] = dig;
                end
            end
            nxt = m_owner;
            if (m_owner < 0) begin
                if (req != 3'b000) nxt = next_after(req, m_ptr);
            end else begin
                others = req & ~(3'b001 << m_owner);
                if (!req[m_owner]) begin
                    m_ptr = m_owner;
                    nxt   = next_after(others, m_owner);
                end else if (m_age >= HOLD - 1 && others != 3'b000) begin
                    m_ptr = m_owner;
                    nxt   = next_after(others, m_owner);
                end
            end
            if (nxt != m_owner || m_owner < 0 || !blink[m_owner]) m_run = 0;
            else m_run++;
            if (nxt != m_owner) m_age = 0;
            else m_age++;
            m_owner = nxt;
        end
        m_gnt = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    endtask

    // One clock: advance the model with the current inputs, then sample after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       rst;
        logic [2:0] req;
        logic [2:0] blink;
        logic [2:0] gnt;
        logic [5:0] i0;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [2:0] b,
                                input logic [2:0] g, input logic [5:0] d);
        vec_t v;
        v.rst = r; v.req = q; v.blink = b; v.gnt = g; v.i0 = d;
        return v;
    endfunction

    initial begin
        logic [63:0] rnd;
        logic [47:0] live;

        // Table frames: every digit enabled; digit0 = 0x22 / 0x2B / 0x34.
        for (int k = 0; k < 8; k++) begin
            frame0[6*k +: 6] = {1'b1, 4'(1 + k),  1'b0};
            frame1[6*k +: 6] = {1'b1, 4'(5 + k),  1'b1};
            frame2[6*k +: 6] = {1'b1, 4'(10 + k), 1'b0};
        end

        //               rst  req     blink   gnt     I0
        vecs[0]  = mk(1'b1, 3'b111, 3'b000, 3'b000, 6'h00);   // reset held
        vecs[1]  = mk(1'b1, 3'b111, 3'b000, 3'b000, 6'h00);
        vecs[2]  = mk(1'b1, 3'b111, 3'b000, 3'b000, 6'h00);
        vecs[3]  = mk(1'b0, 3'b111, 3'b000, 3'b001, 6'h00);   // client 0 first
        vecs[4]  = mk(1'b0, 3'b011, 3'b000, 3'b001, 6'h22);
        vecs[5]  = mk(1'b0, 3'b011, 3'b000, 3'b001, 6'h22);
        vecs[6]  = mk(1'b0, 3'b011, 3'b000, 3'b001, 6'h22);
        vecs[7]  = mk(1'b0, 3'b011, 3'b000, 3'b010, 6'h22);   // hold expired
        vecs[8]  = mk(1'b0, 3'b011, 3'b000, 3'b010, 6'h2B);
        vecs[9]  = mk(1'b0, 3'b011, 3'b000, 3'b010, 6'h2B);
        vecs[10] = mk(1'b0, 3'b011, 3'b000, 3'b010, 6'h2B);
        vecs[11] = mk(1'b0, 3'b011, 3'b000, 3'b001, 6'h2B);
        vecs[12] = mk(1'b0, 3'b101, 3'b000, 3'b001, 6'h22);
        vecs[13] = mk(1'b0, 3'b100, 3'b000, 3'b100, 6'h22);   // drop, direct handover
        vecs[14] = mk(1'b0, 3'b110, 3'b000, 3'b100, 6'h34);
        vecs[15] = mk(1'b0, 3'b110, 3'b000, 3'b100, 6'h34);
        vecs[16] = mk(1'b0, 3'b110, 3'b000, 3'b100, 6'h34);   // hold was reloaded
        vecs[17] = mk(1'b0, 3'b110, 3'b000, 3'b010, 6'h34);
        vecs[18] = mk(1'b0, 3'b000, 3'b000, 3'b000, 6'h2B);   // idle
        vecs[19] = mk(1'b0, 3'b000, 3'b000, 3'b000, 6'h00);
        vecs[20] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h00);   // blink owner 1
        vecs[21] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h2B);
        vecs[22] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h2B);
        vecs[23] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h0B);
        vecs[24] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h0B);
        vecs[25] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h2B);
        vecs[26] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h2B);
        vecs[27] = mk(1'b0, 3'b010, 3'b000, 3'b010, 6'h2B);   // blink dropped in off phase
        vecs[28] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h2B);
        vecs[29] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h2B);
        vecs[30] = mk(1'b0, 3'b010, 3'b010, 3'b010, 6'h0B);
        vecs[31] = mk(1'b1, 3'b010, 3'b010, 3'b000, 6'h00);   // reset mid-blink
        vecs[32] = mk(1'b0, 3'b111, 3'b000, 3'b001, 6'h00);
        vecs[33] = mk(1'b0, 3'b000, 3'b000, 3'b000, 6'h22);
        vecs[34] = mk(1'b0, 3'b000, 3'b000, 3'b000, 6'h00);

        for (int i = 0; i < NVEC; i++) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            blink = vecs[i].blink;
            tick();
            check($sformatf("vec%0d gnt", i),  64'(gnt),  64'(vecs[i].gnt));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(|vecs[i].gnt));
            check($sformatf("vec%0d I0", i),   64'(I0),   64'(vecs[i].i0));
            check($sformatf("vec%0d en", i),
                  64'({I7[5], I6[5], I5[5], I4[5], I3[5], I2[5], I1[5], I0[5]}),
                  64'({8{vecs[i].i0[5]}}));
        end

        // Sole owner keeps the grant indefinitely; live frame changes pass through.
        reset = 1'b1; req = 3'b000; blink = 3'b000;
        tick();
        reset = 1'b0; req = 3'b001;
        tick();
        check("sole grant", 64'(gnt), 64'(3'b001));
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("sole keep%0d", c), 64'(gnt), 64'(3'b001));
        end
        rnd    = {$urandom(), $urandom()};
        live   = rnd[47:0];
        frame0 = live;
        tick();
        check("live frame", 64'(all_i), 64'(live));
        // Hold is already exhausted, so a new requester takes over at once.
        req = 3'b011;
        tick();
        check("saturated rotate", 64'(gnt), 64'(3'b010));

        // Randomized run against the model.
        reset = 1'b1;
        tick();
        for (int c = 0; c < NRAND; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) req[b]   = ~req[b];
                if ($urandom_range(0, 9) == 0) blink[b] = ~blink[b];
            end
            if ($urandom_range(0, 3) == 0) begin rnd = {$urandom(), $urandom()}; frame0 = rnd[47:0]; end
            if ($urandom_range(0, 3) == 0) begin rnd = {$urandom(), $urandom()}; frame1 = rnd[47:0]; end
            if ($urandom_range(0, 3) == 0) begin rnd = {$urandom(), $urandom()}; frame2 = rnd[47:0]; end
            tick();
            check($sformatf("rand%0d gnt", c),  64'(gnt),   64'(m_gnt));
            check($sformatf("rand%0d busy", c), 64'(busy),  64'(|m_gnt));
            check($sformatf("rand%0d I", c),    64'(all_i), 64'(m_i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
